run_stop_ctrl: RTL and testbench
================================

RUN_STOP_CTRL -- requirements
Module: run_stop_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: accumulator, threshold and timeout width.
REQ-002 SHALL have parameter STEP_W, default 8: increment width.
REQ-003 SHALL have parameter HOLD, default 4: cycles spent in STOPPED before DONE (HOLD>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  begin a run; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  cancel the run from any state.
REQ-008 SHALL have port tick  input  1  advance enable; one increment per high cycle in RUN.
REQ-009 SHALL have port step  input  STEP_W  increment added per tick.
REQ-010 SHALL have port threshold  input  CNT_W  stop point for the accumulator.
REQ-011 SHALL have port limit  input  CNT_W  timeout in RUN cycles; 0 disables timeout.
REQ-012 SHALL have port count  output  CNT_W  accumulator value.
REQ-013 SHALL have port stop_flag  output  1  high in STOPPED.
REQ-014 SHALL have port finish  output  1  one-cycle pulse in DONE.
REQ-015 SHALL have port timeout  output  1  sticky; set when the run ended by timeout.
REQ-016 SHALL have port busy  output  1  high in RUN, STOPPED and DONE.
REQ-017 SHALL have port state  output  2  IDLE=0, RUN=1, STOPPED=2, DONE=3.

Function
REQ-018 SHALL capture step, threshold and limit into internal registers on the IDLE->RUN transition; input changes during a run have no effect.
REQ-019 SHALL move IDLE->RUN on start=1 and abort=0, clearing count, the cycle timer and timeout in that same edge.
REQ-020 SHALL, in RUN with tick=1, update count <= count+step, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL, in RUN, increment the cycle timer every cycle regardless of tick.
REQ-022 SHALL move RUN->STOPPED on the first edge where registered count >= captured threshold; the tick in that cycle is ignored and count holds.
REQ-023 SHALL move RUN->DONE with timeout<=1 when limit!=0, the timer equals limit, and the threshold is not met; threshold takes priority when both hold in the same cycle.
REQ-024 SHALL, with threshold=0, enter STOPPED on the first RUN cycle with count=0.
REQ-025 SHALL, with step=0, keep count constant; only timeout or abort leaves RUN.
REQ-026 SHALL hold count and stop_flag=1 for exactly HOLD cycles in STOPPED, then go to DONE.
REQ-027 SHALL spend exactly one cycle in DONE with finish=1, then return to IDLE; count and timeout hold until the next start.
REQ-028 SHALL, on abort=1 in any non-IDLE state, go to IDLE next edge with finish=0 and clear stop_flag; abort overrides start, threshold and timeout in the same cycle.
REQ-029 SHALL drive all outputs from registers, or from state decode only (stop_flag, finish, busy).

Reset
REQ-030 SHALL, on rst=1, force state=IDLE, count=0, timer=0, stop_flag=0, finish=0, timeout=0 and busy=0 immediately, without waiting for a clock edge, including mid-run.
REQ-031 SHALL ignore start while rst=1 and begin sampling start on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover step=10, threshold=100, limit=0, tick always 1: count reaches 100 after 10 ticks, stop_flag high 4 cycles, then finish pulse and IDLE.
REQ-033 SHALL cover step=30, threshold=100: count goes 30,60,90,120; STOPPED is entered with count=120 and count holds at 120.
REQ-034 SHALL cover step=0, limit=20: DONE after 20 RUN cycles with timeout=1, stop_flag never high, finish pulses once.
REQ-035 SHALL cover step=255, threshold=0xFFFF, CNT_W=16: count saturates at 0xFFFF and does not wrap, then STOPPED.
REQ-036 SHALL cover abort asserted on cycle 5 of RUN, and separately in STOPPED: IDLE next edge, finish stays 0, stop_flag drops.
REQ-037 SHALL cover rst asserted between clock edges mid-RUN: all outputs zero before the next edge; a new start after release restarts from count=0.

Source files
------------

// File: rtl/run_stop_ctrl.sv
`default_nettype none
// ============================================================================
// run_stop_ctrl : tick-driven saturating accumulator with threshold stop,
//                 fixed hold in STOPPED, optional run timeout and abort.
// Revision: 1.0
// ============================================================================
module run_stop_ctrl #(
   parameter int CNT_W  = 16,
   parameter int STEP_W = 8,
   parameter int HOLD   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              tick,
   input  logic [STEP_W-1:0] step,
   input  logic [CNT_W-1:0]  threshold,
   input  logic [CNT_W-1:0]  limit,
   output logic [CNT_W-1:0]  count,
   output logic              stop_flag,
   output logic              finish,
   output logic              timeout,
   output logic              busy,
   output logic [1:0]        state
);

   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_STOPPED = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W-1:0]    timer_q, timer_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                timeout_q, timeout_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [CNT_W-1:0]    thr_q, thr_d;
   logic [CNT_W-1:0]    limit_q, limit_d;

   logic [CNT_W:0]      w_sum;
   logic [CNT_W-1:0]    w_timer_inc;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      timer_d     = timer_q;
      hold_d      = hold_q;
      timeout_d   = timeout_q;
      step_d      = step_q;
      thr_d       = thr_q;
      limit_d     = limit_q;
      // Extra carry bit detects overflow for saturation.
      w_sum       = (CNT_W+1)'(count_q) + (CNT_W+1)'(step_q);
      w_timer_inc = timer_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d   = ST_RUN;
               count_d   = '0;
               timer_d   = '0;
               timeout_d = 1'b0;
               step_d    = step;
               thr_d     = threshold;
               limit_d   = limit;
            end
         end
         ST_RUN: begin
            timer_d = w_timer_inc;
            if (abort) begin
               state_d = ST_IDLE;
            end else if (count_q >= thr_q) begin
               state_d = ST_STOPPED;
               hold_d  = '0;
            end else begin
               // Timeout fires at the end of the limit-th RUN cycle.
               if ((limit_q != '0) && (w_timer_inc == limit_q)) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
               end
               if (tick) begin
                  count_d = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
               end
            end
         end
         ST_STOPPED: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hold_q == HOLD_W'(HOLD - 1)) begin
               state_d = ST_DONE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         timer_q   <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
         step_q    <= '0;
         thr_q     <= '0;
         limit_q   <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
         step_q    <= step_d;
         thr_q     <= thr_d;
         limit_q   <= limit_d;
      end
   end

   assign count     = count_q;
   assign timeout   = timeout_q;
   assign state     = state_q;
   assign stop_flag = (state_q == ST_STOPPED);
   assign finish    = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_run_stop_ctrl.sv
`default_nettype none
// ============================================================================
// tb_run_stop_ctrl : directed self-checking bench for run_stop_ctrl.
// Revision: 1.0
// ============================================================================
module tb_run_stop_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort, tick;
   logic [7:0]  step;
   logic [15:0] threshold, limit;
   logic [15:0] count;
   logic        stop_flag, finish, timeout, busy;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   run_stop_ctrl #(.CNT_W(16), .STEP_W(8), .HOLD(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .tick(tick),
      .step(step), .threshold(threshold), .limit(limit), .count(count),
      .stop_flag(stop_flag), .finish(finish), .timeout(timeout),
      .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic begin_run(input logic [7:0] s, input logic [15:0] th, input logic [15:0] lim);
      step = s; threshold = th; limit = lim; tick = 1'b1; abort = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; abort = 1'b0; tick = 1'b0;
      step = 8'd0; threshold = 16'd0; limit = 16'd0;
      cyc(3);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
      checks++; if ({busy, stop_flag, finish, timeout} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {busy, stop_flag, finish, timeout}); end
      rst = 1'b0;
      cyc(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_release_start got=%0d exp=1", state); end
      start = 1'b0; abort = 1'b1;
      cyc(1);
      checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_abort state=%0d busy=%b exp=0,0", state, busy); end
      abort = 1'b0;
   endtask

   task automatic test_basic;
      begin_run(8'd10, 16'd100, 16'd0);
      // Inputs changed mid-run must not affect the captured values.
      step = 8'd1; threshold = 16'd5; limit = 16'd3;
      checks++; if (state !== 2'd1 || count !== 16'd0) begin errors++; $display("FAIL basic_enter state=%0d count=%0d exp=1,0", state, count); end
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         checks++; if (count !== 16'(10 * i) || state !== 2'd1) begin errors++; $display("FAIL basic_count i=%0d count=%0d state=%0d exp=%0d,1", i, count, state, 10 * i); end
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         checks++; if (state !== 2'd2 || stop_flag !== 1'b1 || count !== 16'd100) begin errors++; $display("FAIL basic_stopped i=%0d state=%0d stop=%b count=%0d exp=2,1,100", i, state, stop_flag, count); end
      end
      cyc(1);
      checks++; if (state !== 2'd3 || finish !== 1'b1 || stop_flag !== 1'b0) begin errors++; $display("FAIL basic_done state=%0d finish=%b stop=%b exp=3,1,0", state, finish, stop_flag); end
      cyc(1);
      checks++; if (state !== 2'd0 || finish !== 1'b0 || count !== 16'd100 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle state=%0d finish=%b count=%0d busy=%b exp=0,0,100,0", state, finish, count, busy); end
   endtask

   task automatic test_overshoot;
      begin_run(8'd30, 16'd100, 16'd0);
      tick = 1'b0;
      cyc(1);
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL over_notick count=%0d exp=0", count); end
      tick = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         checks++; if (count !== 16'(30 * i) || state !== 2'd1) begin errors++; $display("FAIL over_count i=%0d count=%0d state=%0d exp=%0d,1", i, count, state, 30 * i); end
      end
      cyc(1);
      checks++; if (state !== 2'd2 || count !== 16'd120) begin errors++; $display("FAIL over_stop state=%0d count=%0d exp=2,120", state, count); end
      cyc(1);
      checks++; if (count !== 16'd120) begin errors++; $display("FAIL over_hold count=%0d exp=120", count); end
      cyc(3);
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL over_finish got=%b exp=1", finish); end
      cyc(1);
   endtask

   task automatic test_timeout;
      int stop_seen;
      stop_seen = 0;
      begin_run(8'd0, 16'd100, 16'd20);
      for (int i = 0; i < 19; i++) begin
         if (stop_flag) stop_seen++;
         cyc(1);
      end
      checks++; if (state !== 2'd1 || timeout !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL to_run20 state=%0d timeout=%b count=%0d exp=1,0,0", state, timeout, count); end
      cyc(1);
      checks++; if (state !== 2'd3 || timeout !== 1'b1 || finish !== 1'b1) begin errors++; $display("FAIL to_done state=%0d timeout=%b finish=%b exp=3,1,1", state, timeout, finish); end
      cyc(1);
      checks++; if (state !== 2'd0 || timeout !== 1'b1 || finish !== 1'b0) begin errors++; $display("FAIL to_idle state=%0d timeout=%b finish=%b exp=0,1,0", state, timeout, finish); end
      checks++; if (stop_seen !== 0) begin errors++; $display("FAIL to_stopflag seen=%0d exp=0", stop_seen); end
   endtask

   task automatic test_priority_abort_stopped;
      begin_run(8'd10, 16'd20, 16'd3);
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL prio_clear timeout=%b exp=0", timeout); end
      cyc(3);
      checks++; if (state !== 2'd2 || timeout !== 1'b0 || count !== 16'd20) begin errors++; $display("FAIL prio_thr state=%0d timeout=%b count=%0d exp=2,0,20", state, timeout, count); end
      abort = 1'b1;
      cyc(1);
      checks++; if (state !== 2'd0 || stop_flag !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL abort_stopped state=%0d stop=%b finish=%b exp=0,0,0", state, stop_flag, finish); end
      abort = 1'b0;
   endtask

   task automatic test_abort_run;
      begin_run(8'd1, 16'd100, 16'd0);
      cyc(4);
      checks++; if (count !== 16'd4 || state !== 2'd1) begin errors++; $display("FAIL abort_pre count=%0d state=%0d exp=4,1", count, state); end
      abort = 1'b1;
      cyc(1);
      checks++; if (state !== 2'd0 || finish !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_run state=%0d finish=%b busy=%b exp=0,0,0", state, finish, busy); end
      start = 1'b1;
      cyc(1);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_over_start state=%0d exp=0", state); end
      start = 1'b0; abort = 1'b0;
   endtask

   task automatic test_saturate;
      begin_run(8'd255, 16'hFFFF, 16'd0);
      cyc(257);
      checks++; if (count !== 16'hFFFF || state !== 2'd1) begin errors++; $display("FAIL sat255_count count=%h state=%0d exp=ffff,1", count, state); end
      cyc(1);
      checks++; if (count !== 16'hFFFF || state !== 2'd2) begin errors++; $display("FAIL sat255_stop count=%h state=%0d exp=ffff,2", count, state); end
      abort = 1'b1; cyc(1); abort = 1'b0;
      begin_run(8'd200, 16'hFFFF, 16'd0);
      cyc(327);
      checks++; if (count !== 16'd65400) begin errors++; $display("FAIL sat200_pre count=%0d exp=65400", count); end
      cyc(1);
      checks++; if (count !== 16'hFFFF || state !== 2'd1) begin errors++; $display("FAIL sat200_clip count=%h state=%0d exp=ffff,1", count, state); end
      cyc(1);
      checks++; if (count !== 16'hFFFF || state !== 2'd2) begin errors++; $display("FAIL sat200_stop count=%h state=%0d exp=ffff,2", count, state); end
      abort = 1'b1; cyc(1); abort = 1'b0;
   endtask

   task automatic test_threshold_zero;
      begin_run(8'd5, 16'd0, 16'd0);
      cyc(1);
      checks++; if (state !== 2'd2 || count !== 16'd0) begin errors++; $display("FAIL thr0 state=%0d count=%0d exp=2,0", state, count); end
      abort = 1'b1; cyc(1); abort = 1'b0;
   endtask

   task automatic test_async_reset;
      begin_run(8'd10, 16'd100, 16'd0);
      cyc(2);
      checks++; if (count !== 16'd20) begin errors++; $display("FAIL arst_pre count=%0d exp=20", count); end
      #3 rst = 1'b1;
      #1;
      checks++; if (state !== 2'd0 || count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL arst_immediate state=%0d count=%0d busy=%b exp=0,0,0", state, count, busy); end
      #2 rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (state !== 2'd1 || count !== 16'd0) begin errors++; $display("FAIL arst_restart state=%0d count=%0d exp=1,0", state, count); end
      cyc(1);
      checks++; if (count !== 16'd10) begin errors++; $display("FAIL arst_count count=%0d exp=10", count); end
      abort = 1'b1; cyc(1); abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overshoot();
      test_timeout();
      test_priority_abort_stopped();
      test_abort_run();
      test_saturate();
      test_threshold_zero();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
